// File: rtl/mem_access_unit_if.sv
// Memory bus between the access unit (master) and the memory (slave).
// Requests are word aligned; bus_ack is a single-cycle completion pulse.
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// Multicycle-CPU memory access unit: turns controller read/write requests into
// bus transactions, fills IR/MDR, stalls the controller and flags errors.
module mem_access_unit #(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read_i,
  input  logic               mem_write_i,
  input  logic               ir_write_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  output logic               stall_o,
  output logic [31:0]        ir_o,
  output logic [31:0]        mdr_o,
  output logic               misalign_err_o,
  output logic               timeout_err_o,
  mem_access_unit_if.master  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q;
  logic [4:0]  waitCnt_q;
  logic [4:0]  waitCnt_d;
  logic        irWrite_q;
  logic        busReq_q;
  logic        busWe_q;
  logic [31:0] busAddr_q;
  logic [31:0] busWdata_q;
  logic [31:0] ir_q;
  logic [31:0] mdr_q;
  logic        misalignErr_q;
  logic        timeoutErr_q;

  logic        request;
  logic        aligned;
  logic        timeoutHit;
  logic [31:0] readData;

  assign request    = mem_read_i | mem_write_i;
  assign aligned    = (addr_i[1:0] == 2'b00);
  assign waitCnt_d  = waitCnt_q + 5'd1;
  assign timeoutHit = (waitCnt_q == 5'(ACK_TIMEOUT - 1));
  // A transaction that ends without an ack completes with the error pattern.
  assign readData   = bus.bus_ack ? bus.bus_rdata : ERR_DATA;

  assign stall_o = ((state_q == IDLE) && request && aligned) || (state_q == BUSY);

  assign ir_o           = ir_q;
  assign mdr_o          = mdr_q;
  assign misalign_err_o = misalignErr_q;
  assign timeout_err_o  = timeoutErr_q;

  assign bus.bus_req   = busReq_q;
  assign bus.bus_we    = busWe_q;
  assign bus.bus_addr  = busAddr_q;
  assign bus.bus_wdata = busWdata_q;

  // The bus registers double as the latched transaction, so they are loaded
  // on entry to BUSY and cleared on exit to keep the bus quiet when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      waitCnt_q     <= 5'd0;
      irWrite_q     <= 1'b0;
      busReq_q      <= 1'b0;
      busWe_q       <= 1'b0;
      busAddr_q     <= 32'd0;
      busWdata_q    <= 32'd0;
      ir_q          <= 32'd0;
      mdr_q         <= 32'd0;
      misalignErr_q <= 1'b0;
      timeoutErr_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (request && !aligned) begin
            misalignErr_q <= 1'b1;
          end else if (request) begin
            state_q    <= BUSY;
            waitCnt_q  <= 5'd0;
            irWrite_q  <= ir_write_i;
            busReq_q   <= 1'b1;
            busWe_q    <= mem_write_i;
            busAddr_q  <= addr_i;
            busWdata_q <= wdata_i;
          end
        end

        BUSY: begin
          if (bus.bus_ack || timeoutHit) begin
            if (!bus.bus_ack) begin
              timeoutErr_q <= 1'b1;
            end
            if (!busWe_q) begin
              mdr_q <= readData;
              if (irWrite_q) begin
                ir_q <= readData;
              end
            end
            state_q    <= DONE;
            busReq_q   <= 1'b0;
            busWe_q    <= 1'b0;
            busAddr_q  <= 32'd0;
            busWdata_q <= 32'd0;
          end else begin
            waitCnt_q <= waitCnt_d;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// transactions scored against a transaction-level model of IR/MDR/errors.
module tb_mem_access_unit;

  localparam int          ACK_TIMEOUT = 16;
  localparam logic [31:0] ERR_DATA    = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] ir;
  logic [31:0] mdr;
  logic        misalign_err;
  logic        timeout_err;

  mem_access_unit_if bus ();

  mem_access_unit #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .ERR_DATA   (ERR_DATA)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read_i    (mem_read),
    .mem_write_i   (mem_write),
    .ir_write_i    (ir_write),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .stall_o       (stall),
    .ir_o          (ir),
    .mdr_o         (mdr),
    .misalign_err_o(misalign_err),
    .timeout_err_o (timeout_err),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  logic [31:0] expIr;
  logic [31:0] expMdr;
  logic        expMisalign;
  logic        expTimeout;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
  endtask

  task automatic clearInputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    addr      = 32'd0;
    wdata     = 32'd0;
  endtask

  task automatic resetModel();
    expIr       = 32'd0;
    expMdr      = 32'd0;
    expMisalign = 1'b0;
    expTimeout  = 1'b0;
  endtask

  // One controller request starting in IDLE at a falling edge; ackDelay is the
  // BUSY cycle index carrying bus_ack (>= ACK_TIMEOUT means memory never answers).
  task automatic applyStimulus(input logic rd, input logic wr, input logic irw,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rdata, input int ackDelay);
    logic [31:0] result;
    bit          acked;
    mem_read    = rd;
    mem_write   = wr;
    ir_write    = irw;
    addr        = a;
    wdata       = wd;
    bus.bus_ack = 1'b0;
    #1;
    if (a[1:0] != 2'b00) begin
      checkOutput("stallMisalign", 32'(stall), 32'd0);
      @(negedge clk);
      expMisalign = 1'b1;
      checkOutput("misalignErr", 32'(misalign_err), 32'(expMisalign));
      checkOutput("busReqMisalign", 32'(bus.bus_req), 32'd0);
      checkOutput("mdrMisalign", mdr, expMdr);
      checkOutput("irMisalign", ir, expIr);
      clearInputs();
      return;
    end
    checkOutput("stallReq", 32'(stall), 32'd1);
    @(negedge clk);
    mem_read  = 1'($urandom);
    mem_write = 1'($urandom);
    ir_write  = 1'($urandom);
    addr      = $urandom;
    wdata     = $urandom;
    acked     = 1'b0;
    for (int k = 0; k < ACK_TIMEOUT && !acked; k++) begin
      checkOutput("busReq", 32'(bus.bus_req), 32'd1);
      checkOutput("stallBusy", 32'(stall), 32'd1);
      if (k == 0) begin
        checkOutput("busAddr", bus.bus_addr, a);
        checkOutput("busWe", 32'(bus.bus_we), 32'(wr));
        if (wr) checkOutput("busWdata", bus.bus_wdata, wd);
      end
      bus.bus_rdata = (k == ackDelay) ? rdata : $urandom;
      bus.bus_ack   = (k == ackDelay);
      acked         = (k == ackDelay);
      @(negedge clk);
      bus.bus_ack = 1'b0;
    end
    if (!wr) begin
      result = acked ? rdata : ERR_DATA;
      expMdr = result;
      if (irw) expIr = result;
    end
    if (!acked) expTimeout = 1'b1;
    checkOutput("busReqDone", 32'(bus.bus_req), 32'd0);
    checkOutput("mdrDone", mdr, expMdr);
    checkOutput("irDone", ir, expIr);
    checkOutput("timeoutErr", 32'(timeout_err), 32'(expTimeout));
    checkOutput("misalignErrDone", 32'(misalign_err), 32'(expMisalign));
    // A new request and a stray ack during DONE must both be ignored.
    mem_read      = 1'b1;
    mem_write     = 1'b0;
    addr          = 32'h200;
    bus.bus_ack   = 1'b1;
    bus.bus_rdata = $urandom;
    #1;
    checkOutput("stallDone", 32'(stall), 32'd0);
    @(negedge clk);
    bus.bus_ack = 1'b0;
    clearInputs();
    checkOutput("mdrIdle", mdr, expMdr);
    checkOutput("irIdle", ir, expIr);
    checkOutput("busReqIdle", 32'(bus.bus_req), 32'd0);
  endtask

  task automatic resetMidBusy();
    mem_read = 1'b1;
    ir_write = 1'b1;
    addr     = 32'h80;
    @(negedge clk);
    clearInputs();
    @(negedge clk);
    checkOutput("busReqBeforeRst", 32'(bus.bus_req), 32'd1);
    rst = 1'b1;
    resetModel();
    #1;
    checkOutput("busReqRst", 32'(bus.bus_req), 32'd0);
    checkOutput("stallRst", 32'(stall), 32'd0);
    checkOutput("timeoutErrRst", 32'(timeout_err), 32'd0);
    checkOutput("misalignErrRst", 32'(misalign_err), 32'd0);
    @(negedge clk);
    rst           = 1'b0;
    bus.bus_ack   = 1'b1;
    bus.bus_rdata = 32'h55AA_33CC;
    @(negedge clk);
    bus.bus_ack = 1'b0;
    checkOutput("irLateAck", ir, expIr);
    checkOutput("mdrLateAck", mdr, expMdr);
    checkOutput("busReqLateAck", 32'(bus.bus_req), 32'd0);
  endtask

  initial begin
    logic        rd;
    logic        wr;
    logic [31:0] a;
    int          op;
    rst           = 1'b1;
    clearInputs();
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = 32'd0;
    resetModel();
    #1;
    checkOutput("irReset", ir, 32'd0);
    checkOutput("mdrReset", mdr, 32'd0);
    checkOutput("busReqReset", 32'(bus.bus_req), 32'd0);
    checkOutput("busWeReset", 32'(bus.bus_we), 32'd0);
    checkOutput("busAddrReset", bus.bus_addr, 32'd0);
    checkOutput("busWdataReset", bus.bus_wdata, 32'd0);
    checkOutput("misalignErrReset", 32'(misalign_err), 32'd0);
    checkOutput("timeoutErrReset", 32'(timeout_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b1, 32'h40, 32'd0, 32'h2008_0005, 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 32'hCAFE_F00D, 32'h0BAD_0BAD, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h102, 32'd0, 32'd0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h44, 32'd0, 32'd0, ACK_TIMEOUT + 5);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h48, 32'd0, 32'h1234_5678, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h4C, 32'h7777_8888, 32'h9999_AAAA, 3);

    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 2));
      rd = (op != 1);
      wr = (op != 0);
      a  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 6) == 0) a = a | 32'($urandom_range(1, 3));
      applyStimulus(rd, wr, 1'($urandom), a, $urandom, $urandom,
                    int'($urandom_range(0, ACK_TIMEOUT + 3)));
    end

    resetMidBusy();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h300, 32'd0, 32'hA5A5_5A5A, 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
